// File: rtl/xgmii_tx_sched_if.sv
// Source-side bus shared by the per-port frame generators and the TX scheduler.
//   vld  per-port word valid
//   txd  per-port 32-bit XGMII data (port i in element i)
//   txc  per-port 4-bit XGMII control
//   eop  per-port last-word-of-frame flag
//   rdy  per-port accept, driven by the scheduler
// master: the sources; slave: the scheduler.
interface xgmii_tx_sched_if #(
  parameter int NUM_PORT = 4
);
  logic [NUM_PORT-1:0]       vld;
  logic [NUM_PORT-1:0][31:0] txd;
  logic [NUM_PORT-1:0][3:0]  txc;
  logic [NUM_PORT-1:0]       eop;
  logic [NUM_PORT-1:0]       rdy;

  modport master (output vld, output txd, output txc, output eop, input rdy);
  modport slave  (input vld, input txd, input txc, input eop, output rdy);
endinterface

// File: rtl/xgmii_tx_sched.sv
// Round-robin whole-frame scheduler sharing one 32-bit XGMII TX lane among
// NUM_PORT sources. Idle (07070707/F) is driven whenever no frame word is being
// forwarded; underruns and over-long frames are cut with FEFEFEFE/F.
// Ports:
//   I_312m5_clk        lane clock, all logic on the rising edge
//   I_rst_n            synchronous reset, active low
//   I_port_en          per-source enable
//   I_ipg_words        idle words after each frame (0 behaves as 1)
//   src                source bus (slave side)
//   O_xgmii_txd/txc    registered lane data/control
//   O_xgmii_txport_num source owning the lane (holds in IDLE)
//   O_pkt_cnt          frames completed with eop, wrapping
//   O_err_pulse        one-cycle pulse on underrun or watchdog abort
module xgmii_tx_sched #(
  parameter int NUM_PORT  = 4,
  parameter int MAX_WORDS = 512
) (
  input  logic                I_312m5_clk,
  input  logic                I_rst_n,
  input  logic [NUM_PORT-1:0] I_port_en,
  input  logic [3:0]          I_ipg_words,
  xgmii_tx_sched_if.slave     src,
  output logic [31:0]         O_xgmii_txd,
  output logic [3:0]          O_xgmii_txc,
  output logic [1:0]          O_xgmii_txport_num,
  output logic [15:0]         O_pkt_cnt,
  output logic                O_err_pulse
);
  localparam logic [31:0] IDLE_W = 32'h0707_0707;
  localparam logic [31:0] ERR_W  = 32'hFEFE_FEFE;
  localparam logic [11:0] WD_LIM = 12'(MAX_WORDS);
  localparam logic [2:0]  NP     = 3'(NUM_PORT);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_IPG} state_t;

  state_t      state_q;
  logic [1:0]  sel_q, rr_q;
  logic [11:0] wcnt_q;
  logic [3:0]  ipg_q;
  logic [31:0] txd_q;
  logic [3:0]  txc_q;
  logic [15:0] pkt_q;
  logic        err_q;

  // View of the source currently owning the lane
  logic        cur_vld, cur_eop;
  logic [31:0] cur_txd;
  logic [3:0]  cur_txc;
  assign cur_vld = src.vld[sel_q];
  assign cur_eop = src.eop[sel_q];
  assign cur_txd = src.txd[sel_q];
  assign cur_txc = src.txc[sel_q];

  logic [3:0] ipg_len;
  assign ipg_len = (I_ipg_words == 4'd0) ? 4'd1 : I_ipg_words;

  logic [NUM_PORT-1:0] elig;
  assign elig = src.vld & I_port_en;

  // Cyclic priority search from rr_q. Walking offsets high-to-low lets the
  // lowest offset (closest to the pointer) overwrite the result last.
  logic       gnt_any;
  logic [1:0] gnt_idx, rr_nxt;
  logic [2:0] arb_sum;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    arb_sum = '0;
    for (int i = NUM_PORT-1; i >= 0; i--) begin
      arb_sum = {1'b0, rr_q} + 3'(i);
      if (arb_sum >= NP) arb_sum = arb_sum - NP;
      if (elig[arb_sum[1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_sum[1:0];
      end
    end
    rr_nxt = (gnt_idx == 2'(NUM_PORT-1)) ? 2'd0 : gnt_idx + 2'd1;
  end

  // Ready only to the owner while it may push words; held low during reset
  // so no source advances on a word that will never reach the lane.
  logic own;
  assign own = I_rst_n && (state_q == S_XFER || state_q == S_DRAIN);
  for (genvar g = 0; g < NUM_PORT; g++) begin : g_rdy
    assign src.rdy[g] = own && (sel_q == 2'(g));
  end

  always_ff @(posedge I_312m5_clk) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      wcnt_q  <= '0;
      ipg_q   <= '0;
      txd_q   <= IDLE_W;
      txc_q   <= 4'hF;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      txd_q <= IDLE_W;
      txc_q <= 4'hF;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            state_q <= S_XFER;
            sel_q   <= gnt_idx;
            rr_q    <= rr_nxt;
            wcnt_q  <= '0;
          end
        end
        S_XFER: begin
          if (wcnt_q == WD_LIM) begin
            // Limit already reached without eop: this word is replaced by /E/.
            // If it happens to carry eop the frame is still closed, just
            // not counted.
            txd_q <= ERR_W;
            err_q <= 1'b1;
            if (cur_vld && cur_eop) begin
              state_q <= S_IPG;
              ipg_q   <= ipg_len;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (!cur_vld) begin
            txd_q   <= ERR_W;
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            txd_q  <= cur_txd;
            txc_q  <= cur_txc;
            wcnt_q <= wcnt_q + 12'd1;
            if (cur_eop) begin
              pkt_q   <= pkt_q + 16'd1;
              state_q <= S_IPG;
              ipg_q   <= ipg_len;
            end
          end
        end
        S_DRAIN: begin
          // A disabled source may never reach eop; release the lane at once
          if (!I_port_en[sel_q] || (cur_vld && cur_eop)) begin
            state_q <= S_IPG;
            ipg_q   <= ipg_len;
          end
        end
        S_IPG: begin
          if (ipg_q <= 4'd1) state_q <= S_IDLE;
          else               ipg_q   <= ipg_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_xgmii_txd        = txd_q;
  assign O_xgmii_txc        = txc_q;
  assign O_xgmii_txport_num = sel_q;
  assign O_pkt_cnt          = pkt_q;
  assign O_err_pulse        = err_q;
endmodule
